// File: rtl/bus_pkg.sv
// Shared definitions for the snooping bus controller: message field positions,
// FSM state encoding and widths of the per-cpu bus words.
package bus_pkg;

    localparam int MSG_W      = 10;
    localparam int BUS_IN_W   = 11;
    localparam int ACK_BIT    = 10;
    localparam int RDMISS_BIT = 9;
    localparam int WRMISS_BIT = 8;
    localparam int INVAL_BIT  = 7;
    localparam int ADDR_HI    = 6;
    localparam int ADDR_LO    = 4;
    localparam int DATA_HI    = 3;
    localparam int DATA_LO    = 0;

    // Stored per-cpu header is msg[9:4]; positions below are relative to it.
    localparam int HDR_W      = RDMISS_BIT - ADDR_LO + 1;
    localparam int HDR_RDMISS = RDMISS_BIT - ADDR_LO;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_BCAST   = 3'd1,
        ST_SNOOP   = 3'd2,
        ST_MEM     = 3'd3,
        ST_RESPOND = 3'd4
    } bus_state_t;

    function automatic logic is_request(input logic [MSG_W-1:0] msg);
        return |msg[RDMISS_BIT:INVAL_BIT];
    endfunction

endpackage

// File: rtl/bus_memory.sv
// Main memory behind the snooping bus: synchronous write, combinational read.
module bus_memory #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 4
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/snoop_bus_controller.sv
// Arbitrates the shared snooping bus between cpus: captures requests, broadcasts the
// round-robin winner, absorbs snooper write-backs and returns ack plus read data.
module snoop_bus_controller
    import bus_pkg::*;
#(
    parameter int NUM_CPUS    = 3,
    parameter int ADDR_W      = 3,
    parameter int DATA_W      = 4,
    parameter int MEM_LATENCY = 2
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [NUM_CPUS*MSG_W-1:0]    cpu_bus_out,
    output logic [NUM_CPUS*BUS_IN_W-1:0] cpu_bus_in,
    input  logic [NUM_CPUS-1:0]          snoop_wb_valid,
    input  logic [NUM_CPUS*DATA_W-1:0]   snoop_wb_data,
    output logic [NUM_CPUS-1:0]          grant,
    output logic                         busy,
    output logic                         protocol_error
);

    localparam int IDX_W = (NUM_CPUS > 1) ? $clog2(NUM_CPUS) : 1;
    localparam int CNT_W = $clog2(MEM_LATENCY + 1);

    // Winner is the first requester strictly after the last one served, wrapping.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_CPUS-1:0] req,
                                                 input logic [IDX_W-1:0]    last);
        logic [IDX_W-1:0] pick;
        logic [IDX_W-1:0] cand;
        pick = last;
        for (int k = NUM_CPUS; k >= 1; k--) begin
            cand = IDX_W'((int'(last) + k) % NUM_CPUS);
            if (req[cand]) pick = cand;
        end
        return pick;
    endfunction

    function automatic logic [NUM_CPUS-1:0] onehot(input logic [IDX_W-1:0] idx);
        return NUM_CPUS'(1) << idx;
    endfunction

    bus_state_t                         state;
    logic [NUM_CPUS-1:0]                pending;
    logic [NUM_CPUS-1:0]                new_req;
    logic [NUM_CPUS-1:0]                clear_mask;
    logic [NUM_CPUS-1:0][HDR_W-1:0]     hdr_in;
    logic [NUM_CPUS-1:0][HDR_W-1:0]     hdr_q;
    logic [NUM_CPUS-1:0][BUS_IN_W-1:0]  bus_in_q;
    logic [NUM_CPUS-1:0][DATA_W-1:0]    wb_data_arr;
    logic [IDX_W-1:0]                   rr_ptr;
    logic [IDX_W-1:0]                   gidx;
    logic [IDX_W-1:0]                   next_g;
    logic [CNT_W-1:0]                   mem_cnt;
    logic                               wb_hit;
    logic [DATA_W-1:0]                  wb_buf;
    logic                               wb_any;
    logic [DATA_W-1:0]                  wb_sel;
    logic [HDR_W-1:0]                   cur_hdr;
    logic [ADDR_W-1:0]                  cur_addr;
    logic [DATA_W-1:0]                  mem_rdata;
    logic                               mem_we;
    logic                               unused_data;

    assign wb_data_arr = snoop_wb_data;
    assign cpu_bus_in  = bus_in_q;
    assign cur_hdr     = hdr_q[gidx];
    assign cur_addr    = cur_hdr[ADDR_W-1:0];
    assign next_g      = rr_pick(pending, rr_ptr);
    assign clear_mask  = (state == ST_RESPOND) ? onehot(gidx) : '0;

    // The data nibble of a request is never forwarded, only its header.
    always_comb begin
        unused_data = 1'b0;
        for (int i = 0; i < NUM_CPUS; i++) begin
            hdr_in[i]   = cpu_bus_out[i*MSG_W+ADDR_LO +: HDR_W];
            new_req[i]  = is_request(cpu_bus_out[i*MSG_W +: MSG_W]);
            unused_data = unused_data ^ (^cpu_bus_out[i*MSG_W+DATA_LO +: DATA_HI-DATA_LO+1]);
        end
    end

    always_comb begin
        wb_any = 1'b0;
        wb_sel = '0;
        for (int j = NUM_CPUS - 1; j >= 0; j--) begin
            if (snoop_wb_valid[j] && (IDX_W'(j) != gidx)) begin
                wb_any = 1'b1;
                wb_sel = wb_data_arr[j];
            end
        end
    end

    // A write-back landing on a reset edge must not reach memory.
    assign mem_we = (state == ST_SNOOP) && wb_any && reset_n;

    bus_memory #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_bus_memory (
        .clock (clock),
        .we    (mem_we),
        .waddr (cur_addr),
        .wdata (wb_sel),
        .raddr (cur_addr),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            pending        <= '0;
            hdr_q          <= '0;
            bus_in_q       <= '0;
            grant          <= '0;
            busy           <= 1'b0;
            protocol_error <= 1'b0;
            rr_ptr         <= IDX_W'(NUM_CPUS - 1);
            gidx           <= '0;
            mem_cnt        <= '0;
            wb_hit         <= 1'b0;
            wb_buf         <= '0;
        end else begin
            protocol_error <= |(new_req & pending);
            pending        <= (pending | new_req) & ~clear_mask;
            for (int i = 0; i < NUM_CPUS; i++) begin
                if (new_req[i] && !pending[i]) hdr_q[i] <= hdr_in[i];
            end

            case (state)
                ST_IDLE: begin
                    if (|pending) begin
                        gidx   <= next_g;
                        rr_ptr <= next_g;
                        grant  <= onehot(next_g);
                        busy   <= 1'b1;
                        for (int i = 0; i < NUM_CPUS; i++) begin
                            bus_in_q[i] <= (IDX_W'(i) == next_g) ? '0
                                         : {1'b0, hdr_q[next_g], DATA_W'(0)};
                        end
                        state  <= ST_BCAST;
                    end
                end
                ST_BCAST: begin
                    bus_in_q <= '0;
                    state    <= ST_SNOOP;
                end
                ST_SNOOP: begin
                    wb_hit <= wb_any;
                    wb_buf <= wb_sel;
                    if (cur_hdr[HDR_RDMISS]) begin
                        mem_cnt <= CNT_W'(MEM_LATENCY - 1);
                        state   <= ST_MEM;
                    end else begin
                        bus_in_q[gidx] <= {1'b1, cur_hdr, DATA_W'(0)};
                        state          <= ST_RESPOND;
                    end
                end
                ST_MEM: begin
                    if (mem_cnt == '0) begin
                        bus_in_q[gidx] <= {1'b1, cur_hdr, wb_hit ? wb_buf : mem_rdata};
                        state          <= ST_RESPOND;
                    end else begin
                        mem_cnt <= mem_cnt - 1'b1;
                    end
                end
                ST_RESPOND: begin
                    bus_in_q <= '0;
                    grant    <= '0;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snoop_bus_controller.sv
// Bench for snoop_bus_controller: directed vector table, hand-written corner sequences
// and random request bursts checked against a transaction-level model.
module tb_snoop_bus_controller;

    localparam int N  = 3;
    localparam int AW = 3;
    localparam int DW = 4;
    localparam int ML = 2;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic [N*10-1:0] cpu_bus_out;
    logic [N*11-1:0] cpu_bus_in;
    logic [N-1:0]    snoop_wb_valid;
    logic [N*DW-1:0] snoop_wb_data;
    logic [N-1:0]    grant;
    logic            busy;
    logic            protocol_error;

    snoop_bus_controller #(
        .NUM_CPUS    (N),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .MEM_LATENCY (ML)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .cpu_bus_out    (cpu_bus_out),
        .cpu_bus_in     (cpu_bus_in),
        .snoop_wb_valid (snoop_wb_valid),
        .snoop_wb_data  (snoop_wb_data),
        .grant          (grant),
        .busy           (busy),
        .protocol_error (protocol_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          cpu;
        logic [9:0]  msg;
        logic [2:0]  wbv;
        logic [11:0] wbd;
        logic [10:0] resp;
        int          lat;
    } vec_t;

    vec_t        vecs [10];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [3:0]  model_mem [8];
    int          model_rr;
    logic [9:0]  bmsg [N];
    logic [N-1:0] bmask;
    int          got_cpu [$];
    logic [10:0] got_word [$];
    logic [N-1:0] got_grant [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [10:0] bus_in_of(input int i);
        return cpu_bus_in[i*11 +: 11];
    endfunction

    // Reference response: ack, echoed header, memory contents only for a read miss.
    function automatic logic [10:0] exp_resp(input logic [9:0] m);
        return {1'b1, m[9:4], m[9] ? model_mem[m[6:4]] : 4'h0};
    endfunction

    task automatic do_txn(input int cpu, input logic [9:0] msg, input logic [2:0] wbv,
                          input logic [11:0] wbd, input logic [10:0] resp, input int lat,
                          input string tag);
        int seen;
        cpu_bus_out[cpu*10 +: 10] = msg;
        tick();
        cpu_bus_out = '0;
        tick();
        check($sformatf("%s_grant", tag), grant, 1 << cpu);
        check($sformatf("%s_busy", tag), busy, 1);
        for (int j = 0; j < N; j++)
            check($sformatf("%s_bcast%0d", tag, j), bus_in_of(j),
                  (j == cpu) ? 11'h0 : {1'b0, msg[9:4], 4'h0});
        tick();
        check($sformatf("%s_bcast_off", tag), cpu_bus_in, 0);
        snoop_wb_valid = wbv;
        snoop_wb_data  = wbd;
        tick();
        snoop_wb_valid = '0;
        snoop_wb_data  = '0;
        for (int j = 0; j < N; j++) begin
            if (j != cpu && wbv[j]) begin
                model_mem[msg[6:4]] = wbd[j*4 +: 4];
                break;
            end
        end
        seen = 3;
        while (!cpu_bus_in[cpu*11+10] && seen < 20) begin
            tick();
            seen++;
        end
        check($sformatf("%s_lat", tag), seen, lat);
        check($sformatf("%s_resp", tag), bus_in_of(cpu), resp);
        tick();
        check($sformatf("%s_idle", tag), {busy, grant}, 0);
        model_rr = cpu;
    endtask

    task automatic burst(input string tag);
        int         order [$];
        logic [N-1:0] p;
        int         cyc;
        got_cpu.delete();
        got_word.delete();
        got_grant.delete();
        for (int i = 0; i < N; i++)
            if (bmask[i]) cpu_bus_out[i*10 +: 10] = bmsg[i];
        tick();
        cpu_bus_out = '0;
        p = bmask;
        while (p != 0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (model_rr + k) % N;
                if (p[c]) begin
                    order.push_back(c);
                    p[c] = 1'b0;
                    model_rr = c;
                    break;
                end
            end
        end
        cyc = 0;
        while (got_cpu.size() < order.size() && cyc < 40 * N) begin
            tick();
            cyc++;
            for (int i = 0; i < N; i++) begin
                if (cpu_bus_in[i*11+10]) begin
                    got_cpu.push_back(i);
                    got_word.push_back(bus_in_of(i));
                    got_grant.push_back(grant);
                end
            end
        end
        check($sformatf("%s_count", tag), got_cpu.size(), order.size());
        for (int k = 0; k < order.size(); k++) begin
            if (k < got_cpu.size()) begin
                check($sformatf("%s_order%0d", tag, k), got_cpu[k], order[k]);
                check($sformatf("%s_word%0d", tag, k), got_word[k], exp_resp(bmsg[order[k]]));
                check($sformatf("%s_grant%0d", tag, k), got_grant[k], 1 << order[k]);
            end
        end
        tick();
        tick();
        check($sformatf("%s_idle", tag), busy, 0);
    endtask

    initial begin
        logic ok;
        int   acks;
        logic [10:0] word;
        logic [9:0]  orig;

        vecs[0] = '{cpu:0, msg:{3'b001,3'd5,4'h0}, wbv:3'b100, wbd:12'hA00, resp:{1'b1,3'b001,3'd5,4'h0}, lat:3};
        vecs[1] = '{cpu:1, msg:{3'b100,3'd5,4'h0}, wbv:3'b000, wbd:12'h000, resp:{1'b1,3'b100,3'd5,4'hA}, lat:3+ML};
        vecs[2] = '{cpu:1, msg:{3'b100,3'd5,4'h0}, wbv:3'b100, wbd:12'h700, resp:{1'b1,3'b100,3'd5,4'h7}, lat:3+ML};
        vecs[3] = '{cpu:2, msg:{3'b100,3'd5,4'h3}, wbv:3'b000, wbd:12'h000, resp:{1'b1,3'b100,3'd5,4'h7}, lat:3+ML};
        vecs[4] = '{cpu:0, msg:{3'b001,3'd3,4'h0}, wbv:3'b000, wbd:12'h000, resp:{1'b1,3'b001,3'd3,4'h0}, lat:3};
        vecs[5] = '{cpu:2, msg:{3'b010,3'd2,4'h9}, wbv:3'b001, wbd:12'h006, resp:{1'b1,3'b010,3'd2,4'h0}, lat:3};
        vecs[6] = '{cpu:0, msg:{3'b100,3'd2,4'h0}, wbv:3'b111, wbd:12'h385, resp:{1'b1,3'b100,3'd2,4'h8}, lat:3+ML};
        vecs[7] = '{cpu:1, msg:{3'b101,3'd2,4'h0}, wbv:3'b000, wbd:12'h000, resp:{1'b1,3'b101,3'd2,4'h8}, lat:3+ML};
        vecs[8] = '{cpu:2, msg:{3'b011,3'd7,4'hF}, wbv:3'b010, wbd:12'h0C0, resp:{1'b1,3'b011,3'd7,4'h0}, lat:3};
        vecs[9] = '{cpu:0, msg:{3'b100,3'd7,4'h0}, wbv:3'b000, wbd:12'h000, resp:{1'b1,3'b100,3'd7,4'hC}, lat:3+ML};

        for (int a = 0; a < 8; a++) model_mem[a] = 4'h0;
        model_rr       = N - 1;
        cpu_bus_out    = '0;
        snoop_wb_valid = '0;
        snoop_wb_data  = '0;
        reset_n        = 1'b0;
        tick();
        tick();
        check("rst_bus_in", cpu_bus_in, 0);
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_perr", protocol_error, 0);
        reset_n = 1'b1;
        tick();

        for (int v = 0; v < 10; v++)
            do_txn(vecs[v].cpu, vecs[v].msg, vecs[v].wbv, vecs[v].wbd, vecs[v].resp,
                   vecs[v].lat, $sformatf("vec%0d", v));

        // Reset across the SNOOP exit of a read miss with a pending write-back.
        cpu_bus_out[10 +: 10] = {3'b100, 3'd4, 4'h0};
        tick();
        cpu_bus_out = '0;
        tick();
        tick();
        snoop_wb_valid = 3'b001;
        snoop_wb_data  = 12'h00E;
        reset_n        = 1'b0;
        tick();
        tick();
        check("midrst_bus_in", cpu_bus_in, 0);
        check("midrst_grant", grant, 0);
        check("midrst_busy", busy, 0);
        check("midrst_perr", protocol_error, 0);
        reset_n        = 1'b1;
        snoop_wb_valid = '0;
        snoop_wb_data  = '0;
        model_rr       = N - 1;
        ok = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (busy || (|cpu_bus_in)) ok = 1'b0;
        end
        check("midrst_quiet", ok, 1);

        // All three cpus at once right after reset: cpu0 first.
        bmask = 3'b111;
        for (int i = 0; i < N; i++) bmsg[i] = {3'b001, 3'(i + 1), 4'h0};
        burst("rr3");
        check("rr3_g0", got_grant[0], 3'b001);
        check("rr3_g1", got_grant[1], 3'b010);
        check("rr3_g2", got_grant[2], 3'b100);
        bmask = 3'b001;
        bmsg[0] = {3'b010, 3'd1, 4'h5};
        burst("rr_again");
        check("rr_again_g", got_grant[0], 3'b001);

        do_txn(1, {3'b100, 3'd4, 4'h0}, 3'b000, 12'h000, {1'b1, 3'b100, 3'd4, 4'h0}, 3 + ML, "mem_kept");

        for (int b = 0; b < 20; b++) begin
            bmask = 3'($urandom_range(1, 7));
            for (int i = 0; i < N; i++)
                bmsg[i] = {3'($urandom_range(1, 7)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
            burst($sformatf("rnd%0d", b));
        end

        // Resend while the original request is being served.
        orig = {3'b100, 3'd2, 4'h1};
        cpu_bus_out[10 +: 10] = orig;
        tick();
        check("perr_first", protocol_error, 0);
        cpu_bus_out = '0;
        tick();
        cpu_bus_out[10 +: 10] = {3'b001, 3'd6, 4'h0};
        tick();
        check("perr_pulse", protocol_error, 1);
        cpu_bus_out = '0;
        tick();
        check("perr_end", protocol_error, 0);
        acks = 0;
        word = '0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (cpu_bus_in[1*11+10]) begin
                acks++;
                word = bus_in_of(1);
            end
        end
        check("perr_acks", acks, 1);
        check("perr_word", word, exp_resp(orig));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
